// File: rtl/rr_grant_stage.sv
// rr_grant_stage -- registered round-robin arbitration stage.
//
// Purpose:
//   Picks one requesting lane per cycle in round-robin order. The request
//   vector is rotated right by the priority pointer, the lowest set bit of the
//   rotated vector is taken, and that offset is mapped back to an absolute
//   lane. The winner is registered as a one-hot grant plus binary index and
//   presented downstream. The pointer then moves one past the accepted
//   winner, so a lane that keeps requesting is served within N grants.
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A valid output holds its payload stable until it is accepted. Ready may
//   depend combinationally on valid. Upstream, req_vld[i] is lane i's valid
//   and req_rdy[i] is its ready. Downstream, gnt_vld/gnt_rdy carry
//   {gnt_oh, gnt_idx}.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   req_vld  in   N      per-lane request valid
//   req_rdy  out  N      per-lane accept, at most one bit high, combinational
//   gnt_vld  out  1      registered grant valid
//   gnt_rdy  in   1      downstream accepts the grant
//   gnt_oh   out  N      registered one-hot grant
//   gnt_idx  out  IDX_W  registered binary index of the granted lane
//   ptr_o    out  IDX_W  current priority pointer (debug/coverage)

// Circular barrel shifter over W bits. The shift amount must be below W.
// Rotation wraps modulo W, not modulo 2**SH_W. This lets a non-power-of-two
// lane count rotate correctly.
module rr_rot_shift #(
  parameter int W         = 8,
  parameter int SH_W      = 3,
  parameter bit ROT_RIGHT = 1'b1
) (
  input  logic [W-1:0]    din_i,
  input  logic [SH_W-1:0] sh_i,
  output logic [W-1:0]    dout_o
);
  logic [2*W-1:0] dbl;

  // Two copies side by side: shifting the pair and keeping one W-bit window
  // is the same as a W-bit rotate.
  assign dbl = {din_i, din_i};

  if (ROT_RIGHT) begin : g_right
    assign dout_o = W'(dbl >> sh_i);
  end else begin : g_left
    assign dout_o = W'((dbl << sh_i) >> W);
  end
endmodule

module rr_grant_stage #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_vld,
  output logic [N-1:0]     req_rdy,
  output logic             gnt_vld,
  input  logic             gnt_rdy,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] ptr_o
);
  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [N-1:0]     gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic             load_en;
  logic             any_req;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] k;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] winner;
  logic [N-1:0]     win_oh;

  // The output slot can take a new grant when it is empty or being drained.
  assign load_en = !gnt_vld_q || gnt_rdy;
  assign any_req = |req_vld;

  rr_rot_shift #(
    .W         (N),
    .SH_W      (IDX_W),
    .ROT_RIGHT (1'b1)
  ) u_rot (
    .din_i  (req_vld),
    .sh_i   (ptr_q),
    .dout_o (rot)
  );

  // Lowest set bit of the rotated vector is the offset from the pointer.
  always_comb begin
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = IDX_W'(i);
    end
  end

  // Map back to an absolute lane. ptr + k < 2N, so one conditional
  // subtract is enough.
  assign sum    = {1'b0, ptr_q} + {1'b0, k};
  assign winner = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : IDX_W'(sum);
  assign win_oh = N'(1) << winner;

  // Reset keeps the accept low even though load_en is high during reset.
  assign req_rdy = (load_en && any_req && !rst) ? win_oh : '0;

  always_comb begin
    ptr_d     = ptr_q;
    gnt_vld_d = gnt_vld_q;
    gnt_oh_d  = gnt_oh_q;
    gnt_idx_d = gnt_idx_q;
    if (load_en) begin
      if (any_req) begin
        gnt_vld_d = 1'b1;
        gnt_oh_d  = win_oh;
        gnt_idx_d = winner;
        ptr_d     = (winner == LAST) ? '0 : winner + IDX_W'(1);
      end else begin
        // Payload is left as-is. Only the valid drops.
        gnt_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_oh_q  <= '0;
      gnt_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_oh_q  <= gnt_oh_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt_oh  = gnt_oh_q;
  assign gnt_idx = gnt_idx_q;
  assign ptr_o   = ptr_q;
endmodule

// File: tb/tb_rr_grant_stage.sv
module tb_rr_grant_stage;
  logic clk;
  logic rst;

  // Instance 0: N=8
  logic [7:0] req8;
  logic [7:0] rdy_o8;
  logic       gvld8;
  logic       grdy8;
  logic [7:0] goh8;
  logic [2:0] gidx8;
  logic [2:0] ptr8;

  // Instance 1: N=5, non-power-of-two
  logic [4:0] req5;
  logic [4:0] rdy_o5;
  logic       gvld5;
  logic       grdy5;
  logic [4:0] goh5;
  logic [2:0] gidx5;
  logic [2:0] ptr5;

  int checks = 0;
  int failures = 0;

  // Reference model state, indexed by instance.
  int   m_ptr[2];
  logic m_vld[2];
  int   m_idx[2];

  logic [2:0] exp_q8[$];
  logic [2:0] exp_q5[$];

  rr_grant_stage #(.N(8), .IDX_W(3)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req8),
    .req_rdy (rdy_o8),
    .gnt_vld (gvld8),
    .gnt_rdy (grdy8),
    .gnt_oh  (goh8),
    .gnt_idx (gidx8),
    .ptr_o   (ptr8)
  );

  rr_grant_stage #(.N(5), .IDX_W(3)) dut5 (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req5),
    .req_rdy (rdy_o5),
    .gnt_vld (gvld5),
    .gnt_rdy (grdy5),
    .gnt_oh  (goh5),
    .gnt_idx (gidx5),
    .ptr_o   (ptr5)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_ptr[w] = 0;
      m_vld[w] = 1'b0;
      m_idx[w] = 0;
    end
    exp_q8.delete();
    exp_q5.delete();
  endtask

  // One clock cycle on instance w.
  // Inputs are driven at the falling edge. The combinational accept is
  // checked 1 ns later. Registered outputs are checked 1 ns after the
  // rising edge.
  task automatic cycle(input int w, input logic [7:0] req_in, input logic rdy);
    int         n;
    int         win;
    logic       load;
    logic [7:0] req;
    logic [7:0] exp_rdy;
    logic [7:0] act_rdy;
    logic       stall;
    logic [2:0] e;
    logic       a_vld;
    logic [7:0] a_oh;
    logic [2:0] a_idx;
    logic [2:0] a_ptr;

    n   = (w == 0) ? 8 : 5;
    req = req_in & ((w == 0) ? 8'hFF : 8'h1F);
    @(negedge clk);
    if (w == 0) begin
      req8  = req;
      grdy8 = rdy;
    end else begin
      req5  = req[4:0];
      grdy5 = rdy;
    end
    #1;

    // The model scans forward from the pointer. It does not rotate the
    // request vector.
    load    = !m_vld[w] || rdy;
    stall   = m_vld[w] && !rdy;
    win     = -1;
    exp_rdy = '0;
    if (load) begin
      for (int j = 0; j < n; j++) begin
        int l;
        l = (m_ptr[w] + j) % n;
        if (win < 0 && req[l]) win = l;
      end
    end
    if (win >= 0) begin
      exp_rdy[win] = 1'b1;
      if (w == 0) exp_q8.push_back(3'(win));
      else exp_q5.push_back(3'(win));
    end
    act_rdy = (w == 0) ? rdy_o8 : {3'b000, rdy_o5};
    chk((w == 0) ? "req_rdy8" : "req_rdy5", act_rdy, exp_rdy);

    if (load) begin
      if (win >= 0) begin
        m_vld[w] = 1'b1;
        m_idx[w] = win;
        m_ptr[w] = (win + 1) % n;
      end else begin
        m_vld[w] = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    a_vld = (w == 0) ? gvld8 : gvld5;
    a_oh  = (w == 0) ? goh8 : {3'b000, goh5};
    a_idx = (w == 0) ? gidx8 : gidx5;
    a_ptr = (w == 0) ? ptr8 : ptr5;
    chk("gnt_vld", a_vld, m_vld[w]);
    chk("ptr", a_ptr, m_ptr[w]);
    if (win >= 0) begin
      if ((w == 0 && exp_q8.size() == 0) || (w == 1 && exp_q5.size() == 0)) begin
        chk("queue_underflow", 1, 0);
      end else begin
        e = (w == 0) ? exp_q8.pop_front() : exp_q5.pop_front();
        chk("gnt_idx", a_idx, e);
        chk("gnt_oh", a_oh, 64'(1) << e);
      end
    end else if (stall) begin
      // While stalled, the held grant must not change.
      chk("stall_idx", a_idx, m_idx[w]);
      chk("stall_oh", a_oh, 64'(1) << m_idx[w]);
    end
    if (a_vld) chk("idx_range", (a_idx < n) ? 1 : 0, 1);
  endtask

  initial begin
    rst   = 1'b1;
    req8  = '0;
    grdy8 = 1'b0;
    req5  = '0;
    grdy5 = 1'b0;
    model_reset();

    // Reset state. req_rdy must stay low even with all lanes requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    req8 = 8'hFF;
    #1;
    chk("rst_gnt_vld", gvld8, 0);
    chk("rst_gnt_oh", goh8, 0);
    chk("rst_gnt_idx", gidx8, 0);
    chk("rst_ptr", ptr8, 0);
    chk("rst_req_rdy", rdy_o8, 0);
    req8 = 8'h00;
    rst  = 1'b0;

    // 1. Fairness sweep: grants go 0..7 then back to 0.
    for (int i = 0; i < 9; i++) cycle(0, 8'hFF, 1'b1);
    chk("sweep_last_idx", gidx8, 0);

    // 2. Wrap-around pick. The pointer is 1 here; grants 1..4 bring it to 5.
    for (int i = 0; i < 4; i++) cycle(0, 8'hFF, 1'b1);
    chk("pre_ptr5", ptr8, 5);
    cycle(0, 8'b0100_0100, 1'b1);
    chk("wrap_idx6", gidx8, 6);
    chk("wrap_ptr7", ptr8, 7);
    cycle(0, 8'b0100_0100, 1'b1);
    chk("wrap_idx2", gidx8, 2);
    chk("wrap_ptr3", ptr8, 3);

    // 3. Backpressure. Lane 3 is granted, then held for 3 cycles.
    cycle(0, 8'hFF, 1'b1);
    repeat (3) cycle(0, 8'hFF, 1'b0);
    chk("bp_oh", goh8, 8'h08);
    chk("bp_ptr", ptr8, 4);
    cycle(0, 8'hFF, 1'b1);
    chk("bp_next_idx", gidx8, 4);

    // 4. Idle and drain.
    cycle(0, 8'h00, 1'b1);
    cycle(0, 8'h00, 1'b1);
    cycle(0, 8'h02, 1'b1);
    chk("idle_idx1", gidx8, 1);
    repeat (3) cycle(0, 8'h00, 1'b1);
    chk("idle_ptr2", ptr8, 2);
    chk("idle_vld0", gvld8, 0);

    // 5. Non-power-of-two, N=5. Lane 3 moves the pointer to 4.
    cycle(1, 8'b01000, 1'b1);
    chk("n5_ptr4", ptr5, 4);
    cycle(1, 8'b10001, 1'b1);
    chk("n5_idx4", gidx5, 4);
    chk("n5_ptr0", ptr5, 0);
    cycle(1, 8'b10001, 1'b1);
    chk("n5_idx0", gidx5, 0);
    for (int i = 0; i < 150; i++) cycle(1, 8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    // Random traffic on N=8, with requests and backpressure varying.
    for (int i = 0; i < 200; i++) cycle(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // 6. Async reset mid-operation. The reset lands during a stall, between edges.
    cycle(0, 8'hFF, 1'b1);
    cycle(0, 8'hFF, 1'b0);
    chk("pre_rst_vld", gvld8, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt_vld", gvld8, 0);
    chk("async_ptr", ptr8, 0);
    chk("async_req_rdy", rdy_o8, 0);
    @(negedge clk);
    req8 = 8'h00;
    req5 = '0;
    rst  = 1'b0;
    model_reset();
    cycle(0, 8'h80, 1'b1);
    chk("post_rst_idx7", gidx8, 7);
    chk("post_rst_ptr0", ptr8, 0);
    cycle(0, 8'h00, 1'b1);

    if (exp_q8.size() != 0 || exp_q5.size() != 0) chk("queue_leftover", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_grant_stage.md
Name: rr_grant_stage

Overview:
- Registered round-robin arbitration stage for the sorter's multi-lane front end.
- Rotates the lane request vector right by the current priority pointer using a circular right-shift barrel shifter instance in right-rotate mode, and picks the lowest set bit.
- Maps the winner back to an absolute lane index and presents a one-hot grant plus index downstream over a valid/ready handshake.
- Advances the pointer past each accepted winner, so every lane is served within N grants.

Parameters:
- N, 8, number of requesting lanes (2..64; non-power-of-two allowed).
- IDX_W, 3, width of the lane index; must be at least ceil(log2(N)).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_vld  input  N  per-lane request valid.
- req_rdy  output  N  per-lane accept; at most one bit high per cycle; combinational.
- gnt_vld  output  1  registered grant valid.
- gnt_rdy  input  1  downstream accepts the grant.
- gnt_oh  output  N  registered one-hot grant.
- gnt_idx  output  IDX_W  registered binary index of the granted lane.
- ptr_o  output  IDX_W  current priority pointer, for debug and coverage.

Behaviour:
- Reset (async assert, sync release): ptr=0, gnt_vld=0, gnt_oh=0, gnt_idx=0; req_rdy=0 while rst is high.
- load_en = !gnt_vld || gnt_rdy. The output slot is empty, or it is being drained this cycle.
- Arbitration, combinational:
  - rot = req_vld rotated right by ptr, modulo N; rotation is over N bits, not 2^IDX_W.
  - k = index of the lowest set bit of rot.
  - winner = (ptr + k) mod N, computed in IDX_W+1 bits and then conditionally minus N.
- req_rdy[winner] = load_en && |req_vld; all other bits are 0.
- On a clock edge with load_en and |req_vld:
  - gnt_oh <= one-hot of winner.
  - gnt_idx <= winner.
  - gnt_vld <= 1.
  - ptr <= (winner+1) mod N; winner N-1 wraps ptr to 0.
- On a clock edge with load_en and no request: gnt_vld <= 0; gnt_oh and gnt_idx hold their last values; ptr holds.
- On a clock edge with gnt_vld && !gnt_rdy (stall): all outputs and ptr hold; req_rdy = 0.
- Latency: lane accepted in cycle t gives gnt_vld in cycle t+1.
- Throughput: one grant per cycle under continuous gnt_rdy (the drain and the new load happen on the same edge).
- Requests need not be sticky; a lane that drops req_vld before req_rdy is simply not granted.
- A request arriving in the same cycle the pointer passes it is arbitrated with the pre-update ptr.
- Fairness: a continuously requesting lane is granted within N accepted grants.
- gnt_oh is always one-hot or zero and consistent with gnt_idx whenever gnt_vld=1.
- Reset asserted mid-stall drops gnt_vld immediately (async); no grant is replayed after release.
- Assertions for the bench:
  - $onehot0(req_rdy).
  - gnt_idx < N.
  - Outputs stable while gnt_vld && !gnt_rdy.

Test Plan:
1. Fairness sweep. After reset, req_vld=8'hFF held, gnt_rdy=1 → gnt_idx sequence 0,1,2,...,7,0; gnt_vld first high one cycle after reset release plus one edge; ptr_o tracks idx+1.
2. Wrap-around pick. Preload ptr=5 by granting lanes 0..4; then req_vld=8'b0100_0100 → grant lane 6, ptr=7; next cycle grant lane 2 (wrap), ptr=3.
3. Backpressure. Grant lane 3 pending, gnt_rdy=0 for 3 cycles with req_vld=8'hFF → gnt_oh=8'h08 stable, req_rdy=0, ptr=4 unchanged; gnt_rdy=1 → lane 4 granted on the next edge.
4. Idle and drain. Single req on lane 1 for one cycle, gnt_rdy=1 → one grant of idx 1, then gnt_vld=0; ptr stays 2 while req_vld=0.
5. Non-power-of-two. N=5, IDX_W=3, req_vld=5'b10001, ptr=4 → grant lane 4, ptr wraps to 0, next grant lane 0; gnt_idx is never 5..7.
6. Async reset mid-operation. Assert rst between edges while gnt_vld=1 → gnt_vld=0 and ptr_o=0 before the next edge; after release with req_vld=8'h80 → lane 7 granted, ptr=0.
